// File: rtl/mem_writer.sv
// Write-side bus master: emits an absolute store or stack push one byte per cycle.
// Optional NMOS RMW dummy write is built when WRITER_DUMMY_WRITE_EN is defined.
`ifndef REG_WIDTH
  `define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
  `define ADDR_WIDTH 16
`endif

module mem_writer #(
  parameter int                   REG_WIDTH  = `REG_WIDTH,
  parameter int                   ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [REG_WIDTH-1:0] STACK_PAGE = 'h01
) (
  input  logic                   phi1,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_mode,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [1:0]             req_len,
  input  logic [3*REG_WIDTH-1:0] req_data,
  input  logic                   req_rmw,
  input  logic [REG_WIDTH-1:0]   req_old,
  input  logic [REG_WIDTH-1:0]   sp_in,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [REG_WIDTH-1:0]   data_out,
  output logic                   we,
  output logic [REG_WIDTH-1:0]   sp_out,
  output logic                   sp_load,
  output logic                   done
);

`ifdef WRITER_DUMMY_WRITE_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DUMMY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE} state_t;
`endif

  state_t r_state, w_state_nxt;

  // Latched request context; r_base/r_sp/r_k always describe the next byte to emit.
  logic                   r_mode;
  logic [1:0]             r_len;
  logic [1:0]             r_k;
  logic [3*REG_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [REG_WIDTH-1:0]   r_sp;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [REG_WIDTH-1:0]   r_data_out;
  logic                   r_we;
  logic [REG_WIDTH-1:0]   r_sp_out;
  logic                   r_sp_load;
  logic                   r_done;

  logic                   w_idle;
  logic                   w_accept;
  logic                   w_dummy_req;
  logic [1:0]             w_len_eff;
  logic                   w_src_mode;
  logic [1:0]             w_src_len;
  logic [1:0]             w_src_k;
  logic [3*REG_WIDTH-1:0] w_src_data;
  logic [ADDR_WIDTH-1:0]  w_src_base;
  logic [REG_WIDTH-1:0]   w_src_sp;
  logic [ADDR_WIDTH-1:0]  w_src_addr;
  logic [REG_WIDTH-1:0]   w_src_byte;
  logic                   w_last;
  logic                   w_emit;
  logic                   w_dummy_go;

  logic [ADDR_WIDTH-1:0]  w_addr_nxt;
  logic [REG_WIDTH-1:0]   w_data_nxt;
  logic                   w_we_nxt;
  logic [REG_WIDTH-1:0]   w_sp_out_nxt;
  logic                   w_sp_load_nxt;
  logic                   w_done_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle;
  assign w_accept  = req_valid & w_idle;
  assign w_len_eff = (req_len == 2'd0) ? 2'd1 : req_len;

`ifdef WRITER_DUMMY_WRITE_EN
  assign w_dummy_req = ~req_mode & req_rmw;
`else
  logic w_unused_rmw;
  assign w_unused_rmw = ^{req_rmw, req_old};
  assign w_dummy_req  = 1'b0;
`endif

  // In IDLE the first byte is taken straight from the request so it lands on the bus one edge after accept.
  assign w_src_mode = w_idle ? req_mode  : r_mode;
  assign w_src_len  = w_idle ? w_len_eff : r_len;
  assign w_src_k    = w_idle ? 2'd0      : r_k;
  assign w_src_data = w_idle ? req_data  : r_data;
  assign w_src_base = w_idle ? req_addr  : r_base;
  assign w_src_sp   = w_idle ? sp_in     : r_sp;
  assign w_src_addr = w_src_mode ? ADDR_WIDTH'({STACK_PAGE, w_src_sp}) : w_src_base;
  assign w_last     = (w_src_k == (w_src_len - 2'd1));

  // NOTE: every always_comb variable gets a default first so no path can infer a latch.
  always_comb begin
    w_src_byte = w_src_data[REG_WIDTH-1:0];
    case (w_src_k)
      2'd1:    w_src_byte = w_src_data[2*REG_WIDTH-1:REG_WIDTH];
      2'd2:    w_src_byte = w_src_data[3*REG_WIDTH-1:2*REG_WIDTH];
      default: w_src_byte = w_src_data[REG_WIDTH-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef WRITER_DUMMY_WRITE_EN
          w_state_nxt = w_dummy_req ? S_DUMMY : S_WRITE;
`else
          w_state_nxt = S_WRITE;
`endif
        end
      end
      S_WRITE: if (r_done) w_state_nxt = S_IDLE;
`ifdef WRITER_DUMMY_WRITE_EN
      S_DUMMY: w_state_nxt = S_WRITE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_emit = 1'b0;
    case (r_state)
      S_IDLE:  w_emit = w_accept & ~w_dummy_req;
      S_WRITE: w_emit = ~r_done;
`ifdef WRITER_DUMMY_WRITE_EN
      S_DUMMY: w_emit = 1'b1;
`endif
      default: w_emit = 1'b0;
    endcase
    w_dummy_go    = w_accept & w_dummy_req;
    w_we_nxt      = w_emit | w_dummy_go;
    w_done_nxt    = w_emit & w_last;
    w_sp_load_nxt = w_emit & w_last & w_src_mode;
    w_sp_out_nxt  = w_sp_load_nxt ? (w_src_sp - REG_WIDTH'(1)) : r_sp_out;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data_out;
    if (w_dummy_go) begin
      w_addr_nxt = req_addr;
      w_data_nxt = req_old;
    end else if (w_emit) begin
      w_addr_nxt = w_src_addr;
      w_data_nxt = w_src_byte;
    end
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= 1'b0;
      r_len      <= 2'd0;
      r_k        <= 2'd0;
      r_data     <= '0;
      r_base     <= '0;
      r_sp       <= '0;
      r_addr     <= '0;
      r_data_out <= '0;
      r_we       <= 1'b0;
      r_sp_out   <= '0;
      r_sp_load  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_data_out <= w_data_nxt;
      r_we       <= w_we_nxt;
      r_sp_out   <= w_sp_out_nxt;
      r_sp_load  <= w_sp_load_nxt;
      r_done     <= w_done_nxt;
      if (w_accept) begin
        r_mode <= req_mode;
        r_len  <= w_len_eff;
        r_data <= req_data;
      end
      if (w_emit) begin
        r_base <= w_src_base + ADDR_WIDTH'(1);
        r_sp   <= w_src_sp - REG_WIDTH'(1);
        r_k    <= w_src_k + 2'd1;
      end else if (w_accept) begin
        r_base <= req_addr;
        r_sp   <= sp_in;
        r_k    <= 2'd0;
      end
    end
  end

  assign addr     = r_addr;
  assign data_out = r_data_out;
  assign we       = r_we;
  assign sp_out   = r_sp_out;
  assign sp_load  = r_sp_load;
  assign done     = r_done;

endmodule

// File: tb/tb_mem_writer.sv
// Randomized self-checking bench for mem_writer against a byte-list reference model.
module tb_mem_writer;

  logic        phi1 = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic [15:0] req_addr = '0;
  logic [1:0]  req_len = '0;
  logic [23:0] req_data = '0;
  logic        req_rmw = 1'b0;
  logic [7:0]  req_old = '0;
  logic [7:0]  sp_in = '0;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        we;
  logic [7:0]  sp_out;
  logic        sp_load;
  logic        done;

`ifdef WRITER_DUMMY_WRITE_EN
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam bit DUMMY_EN = 1'b0;
`endif

  mem_writer dut (
    .phi1(phi1), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .req_rmw(req_rmw), .req_old(req_old), .sp_in(sp_in), .addr(addr),
    .data_out(data_out), .we(we), .sp_out(sp_out), .sp_load(sp_load), .done(done)
  );

  always #5 phi1 = ~phi1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_sp_out = '0;
  logic [15:0] exp_addr_hold = '0;
  logic [7:0]  exp_data_hold = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    req_mode = 1'($urandom);
    req_addr = 16'($urandom);
    req_len  = 2'($urandom);
    req_data = 24'($urandom);
    req_rmw  = 1'($urandom);
    req_old  = 8'($urandom);
    sp_in    = 8'($urandom);
  endtask

  // Entered and left at a negedge; requests stay offered (with junk) while busy to prove they are ignored.
  task automatic do_request(input string tag, input bit mode, input logic [15:0] a,
                            input logic [1:0] len, input logic [23:0] d, input bit rmw,
                            input logic [7:0] old, input logic [7:0] sp);
    logic [15:0] q_addr[$];
    logic [7:0]  q_data[$];
    bit          q_last[$];
    int          eff;
    int          wait_n;
    eff = (len == 2'd0) ? 1 : int'(len);
    if (DUMMY_EN && !mode && rmw) begin
      q_addr.push_back(a); q_data.push_back(old); q_last.push_back(1'b0);
    end
    for (int k = 0; k < eff; k++) begin
      logic [7:0]  spk;
      logic [15:0] ak;
      spk = sp - 8'(k);
      ak  = a + 16'(k);
      q_addr.push_back(mode ? {8'h01, spk} : ak);
      q_data.push_back(d[8*k +: 8]);
      q_last.push_back(k == eff - 1);
    end

    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(negedge phi1);
      wait_n++;
    end
    if (!req_ready) begin
      check({tag, ".ready_wait"}, req_ready, 1);
      return;
    end
    req_valid = 1'b1; req_mode = mode; req_addr = a; req_len = len;
    req_data = d; req_rmw = rmw; req_old = old; sp_in = sp;
    @(posedge phi1);
    #1 scramble_inputs();

    for (int b = 0; b < q_addr.size(); b++) begin
      @(negedge phi1);
      if (q_last[b] && mode) exp_sp_out = sp - 8'(eff);
      check({tag, ".we"},      we,       1);
      check({tag, ".addr"},    addr,     q_addr[b]);
      check({tag, ".data"},    data_out, q_data[b]);
      check({tag, ".done"},    done,     q_last[b]);
      check({tag, ".sp_load"}, sp_load,  q_last[b] && mode);
      check({tag, ".sp_out"},  sp_out,   exp_sp_out);
      check({tag, ".busy"},    req_ready, 0);
      exp_addr_hold = q_addr[b];
      exp_data_hold = q_data[b];
    end

    @(negedge phi1);
    req_valid = 1'b0;
    check({tag, ".idle_we"},   we,        0);
    check({tag, ".idle_done"}, done,      0);
    check({tag, ".idle_spl"},  sp_load,   0);
    check({tag, ".idle_addr"}, addr,      exp_addr_hold);
    check({tag, ".idle_data"}, data_out,  exp_data_hold);
    check({tag, ".idle_rdy"},  req_ready, 1);
    check({tag, ".idle_sp"},   sp_out,    exp_sp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst.we",      we,       0);
    check("rst.done",    done,     0);
    check("rst.sp_load", sp_load,  0);
    check("rst.addr",    addr,     16'h0000);
    check("rst.data",    data_out, 8'h00);
    check("rst.sp_out",  sp_out,   8'h00);
    repeat (2) @(negedge phi1);
    reset_n = 1'b1;
    @(negedge phi1);
    check("rst.ready", req_ready, 1);

    do_request("abs1",   1'b0, 16'h0200, 2'd1, 24'h00005A, 1'b0, 8'h00, 8'h00);
    do_request("jsr",    1'b1, 16'h0000, 2'd2, 24'h003412, 1'b0, 8'h00, 8'hFD);
    do_request("spwrap", 1'b1, 16'h0000, 2'd3, 24'hC0B0A0, 1'b0, 8'h00, 8'h01);
    do_request("awrap",  1'b0, 16'hFFFF, 2'd2, 24'h002211, 1'b0, 8'h00, 8'h00);
    do_request("len0",   1'b0, 16'h1234, 2'd0, 24'h7766AB, 1'b0, 8'h00, 8'h00);
    do_request("rmw",    1'b0, 16'h0010, 2'd1, 24'h000000, 1'b1, 8'h80, 8'h00);
    do_request("rmwstk", 1'b1, 16'h0010, 2'd1, 24'h000055, 1'b1, 8'h80, 8'h40);

    // Abort a 3-byte push after its first byte.
    req_valid = 1'b1; req_mode = 1'b1; req_len = 2'd3; req_data = 24'h332211;
    req_rmw = 1'b0; sp_in = 8'h50;
    @(posedge phi1);
    #1 scramble_inputs();
    @(negedge phi1);
    check("abort.byte0_addr", addr, 16'h0150);
    check("abort.byte0_data", data_out, 8'h11);
    reset_n = 1'b0;
    #1;
    check("abort.we",      we,      0);
    check("abort.done",    done,    0);
    check("abort.sp_load", sp_load, 0);
    check("abort.addr",    addr,    16'h0000);
    check("abort.sp_out",  sp_out,  8'h00);
    @(posedge phi1);
    #1;
    check("abort.we_hold", we, 0);
    @(negedge phi1);
    reset_n = 1'b1; req_valid = 1'b0;
    exp_sp_out = '0; exp_addr_hold = '0; exp_data_hold = '0;
    @(negedge phi1);
    check("abort.ready", req_ready, 1);
    do_request("post_abort", 1'b1, 16'h0000, 2'd1, 24'h0000EE, 1'b0, 8'h00, 8'hFF);

    for (int i = 0; i < 60; i++) begin
      do_request($sformatf("rnd%0d", i), 1'($urandom), 16'($urandom), 2'($urandom),
                 24'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge phi1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
